// File: rtl/cam_slot_scanner.sv
// Round-robin scan controller driving the CAM validation 8:1 mux selector.
// Finds the first entry, starting from a given index, whose bit matches the requested polarity.
module cam_slot_scanner #(
   parameter int ENTRIES = 8,
   parameter int SEL_W   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             find_valid,
   input  logic [SEL_W-1:0] start_index,
   input  logic             mux_bit,
   output logic [SEL_W-1:0] mux_select,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [SEL_W-1:0] index
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [SEL_W-1:0] LAST_COUNT = SEL_W'(ENTRIES - 1);
   localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_ZERO   = SEL_W'(0);

   state_t           state_q,  state_d;
   logic             target_q, target_d;
   logic [SEL_W-1:0] sel_q,    sel_d;
   logic [SEL_W-1:0] count_q,  count_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             found_q,  found_d;
   logic [SEL_W-1:0] index_q,  index_d;

   // Next-state and next-output logic for the scan FSM
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      sel_d    = sel_q;
      count_d  = count_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      found_d  = found_q;
      index_d  = index_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               target_d = find_valid;
               sel_d    = start_index;
               count_d  = SEL_ZERO;
               found_d  = 1'b0;
               index_d  = SEL_ZERO;
               busy_d   = 1'b1;
               state_d  = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            // mux_bit is combinational from sel_q, so it reflects this cycle's entry
            if (mux_bit == target_q) begin
               found_d = 1'b1;
               index_d = sel_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (count_q == LAST_COUNT) begin
               found_d = 1'b0;
               index_d = SEL_ZERO;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               sel_d   = sel_q + SEL_ONE;
               count_d = count_q + SEL_ONE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         target_q <= 1'b0;
         sel_q    <= SEL_ZERO;
         count_q  <= SEL_ZERO;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         index_q  <= SEL_ZERO;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         sel_q    <= sel_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         found_q  <= found_d;
         index_q  <= index_d;
      end
   end

   assign mux_select = sel_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign found      = found_q;
   assign index      = index_q;

endmodule

// File: tb/tb_cam_slot_scanner.sv
// Directed table-driven bench for cam_slot_scanner; a behavioural 8:1 mux feeds mux_bit.
module tb_cam_slot_scanner;

   typedef struct {
      logic [7:0] vec;
      logic       fv;
      logic [2:0] si;
      logic       exp_found;
      logic [2:0] exp_index;
      int         exp_done;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       find_valid;
   logic [2:0] start_index;
   logic       mux_bit;
   logic [2:0] mux_select;
   logic       busy;
   logic       done;
   logic       found;
   logic [2:0] index;
   logic [7:0] vec;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t tbl[7];

   cam_slot_scanner dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .find_valid  (find_valid),
      .start_index (start_index),
      .mux_bit     (mux_bit),
      .mux_select  (mux_select),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .index       (index)
   );

   assign mux_bit = vec[mux_select];

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_scan(input vec_t t, input string tag);
      int         cyc;
      int         busy_cnt;
      bit         seen;
      logic [2:0] exp_sel;
      @(negedge clk);
      vec = t.vec; find_valid = t.fv; start_index = t.si; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; busy_cnt = 0; seen = 1'b0;
      while (!seen && cyc <= 12) begin
         if (busy) begin
            busy_cnt++;
            exp_sel = t.si + 3'(cyc - 1);
            check({tag, " mux_select"}, int'(mux_select), int'(exp_sel));
         end
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!seen) begin
         check({tag, " done timeout"}, 0, 1);
      end else begin
         check({tag, " done cycle"}, cyc, t.exp_done);
         check({tag, " found"}, int'(found), int'(t.exp_found));
         check({tag, " index"}, int'(index), int'(t.exp_index));
         check({tag, " busy cycles"}, busy_cnt, t.exp_done - 1);
         @(posedge clk); #1;
         check({tag, " done pulse width"}, int'(done), 0);
         repeat (2) @(posedge clk);
         #1;
         check({tag, " idle busy"}, int'(busy), 0);
         check({tag, " found held"}, int'(found), int'(t.exp_found));
         check({tag, " index held"}, int'(index), int'(t.exp_index));
         exp_sel = t.si + 3'(t.exp_done - 2);
         check({tag, " mux_select held"}, int'(mux_select), int'(exp_sel));
      end
   endtask

   initial begin
      tbl[0] = '{vec: 8'b1111_0111, fv: 1'b0, si: 3'd0, exp_found: 1'b1, exp_index: 3'd3, exp_done: 5};
      tbl[1] = '{vec: 8'b0000_0010, fv: 1'b1, si: 3'd6, exp_found: 1'b1, exp_index: 3'd1, exp_done: 5};
      tbl[2] = '{vec: 8'hFF,        fv: 1'b0, si: 3'd5, exp_found: 1'b0, exp_index: 3'd0, exp_done: 9};
      tbl[3] = '{vec: 8'h01,        fv: 1'b1, si: 3'd0, exp_found: 1'b1, exp_index: 3'd0, exp_done: 2};
      tbl[4] = '{vec: 8'h80,        fv: 1'b1, si: 3'd0, exp_found: 1'b1, exp_index: 3'd7, exp_done: 9};
      tbl[5] = '{vec: 8'hFE,        fv: 1'b0, si: 3'd3, exp_found: 1'b1, exp_index: 3'd0, exp_done: 7};
      tbl[6] = '{vec: 8'h00,        fv: 1'b1, si: 3'd2, exp_found: 1'b0, exp_index: 3'd0, exp_done: 9};

      // Reset held two cycles with start high: nothing may start
      reset = 1'b1; start = 1'b1; find_valid = 1'b1; start_index = 3'd5; vec = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset found", int'(found), 0);
      check("reset index", int'(index), 0);
      check("reset mux_select", int'(mux_select), 0);
      start = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      check("post-reset idle busy", int'(busy), 0);
      check("post-reset mux_select", int'(mux_select), 0);

      for (int i = 0; i < 7; i++) begin
         run_scan(tbl[i], $sformatf("vec%0d", i));
      end

      // start held high through SCAN and DONE is dropped
      @(negedge clk);
      vec = 8'h80; find_valid = 1'b1; start_index = 3'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; find_valid = 1'b0; start_index = 3'd4;
      begin
         int cyc;
         cyc = 3;
         while (!done && cyc <= 12) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("ignored start done cycle", cyc, 9);
         check("ignored start found", int'(found), 1);
         check("ignored start index", int'(index), 7);
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("start in DONE dropped busy", int'(busy), 0);
      check("start in DONE dropped done", int'(done), 0);
      check("start in DONE found held", int'(found), 1);
      check("start in DONE index held", int'(index), 7);
      check("start in DONE mux_select", int'(mux_select), 7);
      run_scan(tbl[3], "after ignored");

      // Reset asserted in cycle 4 of a scan that can never match
      @(negedge clk);
      vec = 8'h00; find_valid = 1'b1; start_index = 3'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("midreset busy c%0d", c), int'(busy), 1);
         check($sformatf("midreset done c%0d", c), int'(done), 0);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      check("midreset done c4", int'(done), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset busy", int'(busy), 0);
      check("midreset done", int'(done), 0);
      check("midreset found", int'(found), 0);
      check("midreset index", int'(index), 0);
      check("midreset mux_select", int'(mux_select), 0);
      repeat (3) begin
         @(posedge clk); #1;
         check("midreset no late done", int'(done), 0);
      end
      run_scan(tbl[1], "after midreset");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
